// File: rtl/cpu_params.sv
// Shared fetch-side definitions: reset PC, FSM state encoding and PC alignment helper.
package cpu_params;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1eceb000;
    localparam logic [31:0] PC_ALIGN_MASK    = ~32'h3;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [3:0]  RMASK_WORD       = 4'hf;
    localparam logic [3:0]  RMASK_NONE       = 4'h0;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding word read, one-entry output buffer toward the
// instruction queue, and flush/redirect from the backend.
module fetch_stage
    import cpu_params::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output logic        fifo_valid,
    input  logic        fifo_ready,
    output logic [31:0] fifo_pc,
    output logic [31:0] fifo_inst,
    input  logic        backend_flush,
    input  logic [31:0] backend_redirect_pc
);

    fetch_state_t state, state_next;
    logic [31:0]  pc;
    logic         buf_free;
    logic         issue;
    logic         load;
    logic         transfer;

    assign buf_free  = !fifo_valid || fifo_ready;
    assign transfer  = fifo_valid && fifo_ready;
    assign imem_addr = pc;

    // Requests are suppressed while rst is held so the reset cycle never launches a read.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        load       = 1'b0;
        unique case (state)
            REQ: begin
                if (buf_free && !backend_flush && !rst) begin
                    issue      = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_resp) begin
                    load       = !backend_flush;
                    state_next = REQ;
                end else if (backend_flush) begin
                    state_next = KILL;
                end
            end
            KILL: begin
                if (imem_resp) begin
                    state_next = REQ;
                end
            end
            default: state_next = REQ;
        endcase
    end

    assign imem_rmask = issue ? RMASK_WORD : RMASK_NONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= REQ;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (backend_flush) begin
            pc <= align_pc(backend_redirect_pc);
        end else if (load) begin
            pc <= pc + PC_STEP;
        end
    end

    // A load always lands in a free slot: the read was only issued when the buffer was free.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_valid <= 1'b0;
            fifo_pc    <= '0;
            fifo_inst  <= '0;
        end else begin
            if (backend_flush) begin
                fifo_valid <= 1'b0;
            end else if (load) begin
                fifo_valid <= 1'b1;
            end else if (transfer) begin
                fifo_valid <= 1'b0;
            end
            if (load) begin
                fifo_pc   <= pc;
                fifo_inst <= imem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: vector table, directed corner sequences and randomized traffic
// checked against a transaction-level model of the fetch unit.
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'h1eceb000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        fifo_valid;
    logic        fifo_ready;
    logic [31:0] fifo_pc;
    logic [31:0] fifo_inst;
    logic        backend_flush;
    logic [31:0] backend_redirect_pc;

    int errors = 0;
    int checks = 0;

    // Model: expected fetch PC, whether a read is in flight and whether it is stale, buffer.
    logic [31:0] m_pc;
    bit          m_out;
    bit          m_stale;
    bit          m_valid;
    logic [31:0] m_bpc;
    logic [31:0] m_binst;

    typedef struct {
        logic        rsp;
        logic [31:0] rd;
        logic [3:0]  rm;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;

    vec_t tbl [7];

    fetch_stage #(.RESET_PC(RPC)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .imem_addr           (imem_addr),
        .imem_rmask          (imem_rmask),
        .imem_rdata          (imem_rdata),
        .imem_resp           (imem_resp),
        .fifo_valid          (fifo_valid),
        .fifo_ready          (fifo_ready),
        .fifo_pc             (fifo_pc),
        .fifo_inst           (fifo_inst),
        .backend_flush       (backend_flush),
        .backend_redirect_pc (backend_redirect_pc)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = RPC;
        m_out   = 0;
        m_stale = 0;
        m_valid = 0;
        m_bpc   = '0;
        m_binst = '0;
    endtask

    task automatic drive(input bit fl, input logic [31:0] rpc, input bit rdy,
                         input bit rsp, input logic [31:0] rd);
        backend_flush       = fl;
        backend_redirect_pc = rpc;
        fifo_ready          = rdy;
        imem_resp           = rsp;
        imem_rdata          = rd;
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] rm, input logic [31:0] addr,
                              input logic v, input logic [31:0] pc, input logic [31:0] inst);
        chk({tag, ".rmask"}, {28'd0, imem_rmask}, {28'd0, rm});
        chk({tag, ".addr"}, imem_addr, addr);
        chk({tag, ".valid"}, {31'd0, fifo_valid}, {31'd0, v});
        chk({tag, ".fifo_pc"}, fifo_pc, pc);
        chk({tag, ".fifo_inst"}, fifo_inst, inst);
    endtask

    // Compare against the model for the current cycle, then let the model and DUT take the edge.
    task automatic advance();
        bit exp_issue;
        exp_issue = !m_out && (!m_valid || fifo_ready) && !backend_flush && !rst;
        chk("model.rmask", {28'd0, imem_rmask}, exp_issue ? 32'hf : 32'h0);
        chk("model.addr", imem_addr, m_pc);
        chk("model.valid", {31'd0, fifo_valid}, {31'd0, m_valid});
        chk("model.fifo_pc", fifo_pc, m_bpc);
        chk("model.fifo_inst", fifo_inst, m_binst);
        if (rst) begin
            model_reset();
        end else begin
            if (m_valid && fifo_ready) m_valid = 0;
            if (backend_flush) begin
                m_pc    = backend_redirect_pc & ~32'h3;
                m_valid = 0;
                if (m_out) begin
                    if (imem_resp) begin
                        m_out   = 0;
                        m_stale = 0;
                    end else begin
                        m_stale = 1;
                    end
                end
            end else if (imem_resp && m_out) begin
                if (!m_stale) begin
                    m_valid = 1;
                    m_bpc   = m_pc;
                    m_binst = imem_rdata;
                    m_pc    = m_pc + 32'd4;
                end
                m_out   = 0;
                m_stale = 0;
            end else if (exp_issue) begin
                m_out   = 1;
                m_stale = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 32'h0, 1, 0, 32'h0);
        @(posedge clk);
        #1;
        expect_out("reset", 4'h0, RPC, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        bit          mem_pending;
        int          mem_cnt;
        bit          rsp;
        bit          issued;

        tbl[0] = '{1'b0, 32'h0,        4'hf, RPC,              1'b0, 32'h0,            32'h0};
        tbl[1] = '{1'b1, 32'h00000013, 4'h0, RPC,              1'b0, 32'h0,            32'h0};
        tbl[2] = '{1'b0, 32'h0,        4'hf, 32'h1eceb004,     1'b1, RPC,              32'h00000013};
        tbl[3] = '{1'b1, 32'h00a00093, 4'h0, 32'h1eceb004,     1'b0, RPC,              32'h00000013};
        tbl[4] = '{1'b0, 32'h0,        4'hf, 32'h1eceb008,     1'b1, 32'h1eceb004,     32'h00a00093};
        tbl[5] = '{1'b1, 32'h00108113, 4'h0, 32'h1eceb008,     1'b0, 32'h1eceb004,     32'h00a00093};
        tbl[6] = '{1'b0, 32'h0,        4'hf, 32'h1eceb00c,     1'b1, 32'h1eceb008,     32'h00108113};

        // Steady fetch with a one-cycle memory and an always-ready queue.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(0, 32'h0, 1, tbl[i].rsp, tbl[i].rd);
            expect_out($sformatf("seq1[%0d]", i), tbl[i].rm, tbl[i].addr, tbl[i].v, tbl[i].pc, tbl[i].inst);
            advance();
        end

        // Queue back-pressure right after the first response.
        do_reset();
        drive(0, 32'h0, 1, 0, 32'h0); advance();
        drive(0, 32'h0, 1, 1, 32'hdeadbeef); advance();
        for (int i = 0; i < 5; i++) begin
            drive(0, 32'h0, 0, 0, 32'h0);
            expect_out("stall", 4'h0, 32'h1eceb004, 1'b1, RPC, 32'hdeadbeef);
            advance();
        end
        drive(0, 32'h0, 1, 0, 32'h0);
        expect_out("stall_release", 4'hf, 32'h1eceb004, 1'b1, RPC, 32'hdeadbeef);
        advance();
        drive(0, 32'h0, 1, 1, 32'h11111111); advance();

        // Flush while waiting; the late response is stale.
        do_reset();
        drive(0, 32'h0, 1, 0, 32'h0); advance();
        drive(1, 32'h80000002, 1, 0, 32'h0);
        expect_out("flush_wait", 4'h0, RPC, 1'b0, 32'h0, 32'h0);
        advance();
        for (int i = 0; i < 2; i++) begin
            drive(0, 32'h0, 1, 0, 32'h0);
            expect_out("kill_hold", 4'h0, 32'h80000000, 1'b0, 32'h0, 32'h0);
            advance();
        end
        drive(0, 32'h0, 1, 1, 32'hbadbad00);
        expect_out("kill_resp", 4'h0, 32'h80000000, 1'b0, 32'h0, 32'h0);
        advance();
        drive(0, 32'h0, 1, 0, 32'h0);
        expect_out("after_kill", 4'hf, 32'h80000000, 1'b0, 32'h0, 32'h0);
        advance();
        drive(0, 32'h0, 1, 1, 32'h0000600d); advance();
        drive(0, 32'h0, 1, 0, 32'h0);
        expect_out("redirect_push", 4'hf, 32'h80000004, 1'b1, 32'h80000000, 32'h0000600d);
        advance();

        // Flush coinciding with the response.
        do_reset();
        drive(0, 32'h0, 1, 0, 32'h0); advance();
        drive(1, 32'h40000013, 1, 1, 32'hbadbad11);
        expect_out("flush_resp", 4'h0, RPC, 1'b0, 32'h0, 32'h0);
        advance();
        drive(0, 32'h0, 1, 0, 32'h0);
        expect_out("flush_resp_next", 4'hf, 32'h40000010, 1'b0, 32'h0, 32'h0);
        advance();
        drive(0, 32'h0, 1, 1, 32'h22222222); advance();

        // Back-to-back flushes, then PC wrap-around at the top of the address space.
        do_reset();
        drive(1, 32'h12345678, 1, 0, 32'h0);
        expect_out("flush_a", 4'h0, RPC, 1'b0, 32'h0, 32'h0);
        advance();
        drive(1, 32'hfffffffe, 1, 0, 32'h0);
        expect_out("flush_b", 4'h0, 32'h12345678, 1'b0, 32'h0, 32'h0);
        advance();
        drive(0, 32'h0, 1, 0, 32'h0);
        expect_out("wrap_req", 4'hf, 32'hfffffffc, 1'b0, 32'h0, 32'h0);
        advance();
        drive(0, 32'h0, 1, 1, 32'h00000011); advance();
        drive(0, 32'h0, 1, 0, 32'h0);
        expect_out("wrap_next", 4'hf, 32'h00000000, 1'b1, 32'hfffffffc, 32'h00000011);
        advance();

        // Reset while waiting; the old response arrives afterwards and must be ignored.
        drive(0, 32'h0, 1, 1, 32'h33333333); advance();
        drive(0, 32'h0, 1, 0, 32'h0); advance();
        rst = 1'b1;
        drive(0, 32'h0, 1, 0, 32'h0); advance();
        rst = 1'b0;
        drive(0, 32'h0, 1, 1, 32'hbadbad22);
        expect_out("rst_late_resp", 4'hf, RPC, 1'b0, 32'h0, 32'h0);
        advance();
        drive(0, 32'h0, 1, 0, 32'h0);
        expect_out("rst_wait", 4'h0, RPC, 1'b0, 32'h0, 32'h0);
        advance();
        drive(0, 32'h0, 1, 1, 32'h00000077); advance();
        drive(0, 32'h0, 1, 0, 32'h0);
        expect_out("rst_first_push", 4'hf, 32'h1eceb004, 1'b1, RPC, 32'h00000077);
        advance();

        // Randomized traffic: variable memory latency, back-pressure and flushes.
        do_reset();
        mem_pending = 0;
        mem_cnt     = 0;
        for (int c = 0; c < 800; c++) begin
            rsp = mem_pending && (mem_cnt == 0);
            drive(($urandom_range(0, 15) == 0), $urandom, ($urandom_range(0, 3) != 0), rsp, $urandom);
            issued = (imem_rmask == 4'hf);
            advance();
            if (rsp) mem_pending = 0;
            if (issued) begin
                mem_pending = 1;
                mem_cnt     = $urandom_range(0, 2);
            end else if (mem_pending && mem_cnt > 0) begin
                mem_cnt--;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
